temp_poll_ctrl: RTL

//  Sequencer for the i2c_dri instance that serves the on-board temperature sensor.

---
 rtl/temp_poll_pkg.sv | 30 +++
 rtl/temp_poll_ctrl_timer.sv | 32 +++
 rtl/temp_poll_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/temp_poll_pkg.sv
// Shared constants for the temperature-sensor poll sequencer: FSM encoding,
// default sensor addressing and small arithmetic helpers.
package temp_poll_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CFG_WAIT  = 2'd1;
  localparam logic [1:0] ST_TICK_WAIT = 2'd2;
  localparam logic [1:0] ST_RD_WAIT   = 2'd3;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h48;
  localparam logic [7:0] DEF_CFG_REG    = 8'h03;
  localparam logic [7:0] DEF_CFG_VALUE  = 8'h00;
  localparam logic [7:0] DEF_TEMP_REG   = 8'h00;

  // History slots behind the incoming sample in the 4-sample averaging window.
  localparam int HIST_DEPTH = 3;

  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

  // Truncating mean of four bytes through a 10-bit sum.
  function automatic logic [7:0] mean4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    logic [9:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return 8'(sum >> 2);
  endfunction

endpackage

// File: rtl/temp_poll_ctrl_timer.sv
// poll_timer: clear/enable up-counter that saturates at LIMIT-1 and flags
// the terminal count, so tc is high during the LIMIT-th enabled cycle.
module poll_timer
  import temp_poll_pkg::*;
#(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/temp_poll_ctrl.sv
// temp_poll_ctrl: writes the sensor config once, then polls the temperature
// register through i2c_dri with a hung-transaction timeout. Optional TEMP_AVG_EN
// turns temp_out into a 4-sample running mean.
module temp_poll_ctrl
  import temp_poll_pkg::*;
#(
  parameter int         POLL_CYCLES    = 100_000_000,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [6:0] SLAVE_ADDR     = DEF_SLAVE_ADDR,
  parameter logic [7:0] CFG_REG        = DEF_CFG_REG,
  parameter logic [7:0] CFG_VALUE      = DEF_CFG_VALUE,
  parameter logic [7:0] TEMP_REG       = DEF_TEMP_REG
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       err_clr,
  output logic       i2c_exec,
  output logic       i2c_rd_wr_n,
  output logic [6:0] i2c_slave_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_w_data,
  input  logic       i2c_done,
  input  logic [7:0] i2c_r_data,
  output logic [7:0] temp_out,
  output logic       temp_valid,
  output logic       timeout_err,
  output logic       busy
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       cfg_done;
  logic       in_txn;
  logic       next_in_txn;
  logic       poll_tc;
  logic       wait_tc;
  logic       rd_ok;
  logic       timeout_hit;

  assign in_txn      = (state == ST_CFG_WAIT) || (state == ST_RD_WAIT);
  assign next_in_txn = (state_next == ST_CFG_WAIT) || (state_next == ST_RD_WAIT);
  assign rd_ok       = (state == ST_RD_WAIT) && i2c_done;
  // A done arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = in_txn && wait_tc && !i2c_done;

  assign i2c_slave_addr = SLAVE_ADDR;
  assign i2c_w_data     = CFG_VALUE;

  // Poll interval: held (not cleared) while parked in IDLE.
  poll_timer #(.LIMIT(POLL_CYCLES)) u_poll_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (in_txn),
    .en    (state == ST_TICK_WAIT),
    .tc    (poll_tc)
  );

  poll_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!in_txn),
    .en    (in_txn),
    .tc    (wait_tc)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = cfg_done ? ST_TICK_WAIT : ST_CFG_WAIT;
      end
      ST_CFG_WAIT, ST_RD_WAIT: begin
        if (i2c_done || wait_tc) state_next = ST_TICK_WAIT;
      end
      ST_TICK_WAIT: begin
        if (!enable)      state_next = ST_IDLE;
        else if (poll_tc) state_next = cfg_done ? ST_RD_WAIT : ST_CFG_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cfg_done     <= 1'b0;
      i2c_exec     <= 1'b0;
      busy         <= 1'b0;
      i2c_rd_wr_n  <= 1'b1;
      i2c_reg_addr <= CFG_REG;
      timeout_err  <= 1'b0;
      temp_valid   <= 1'b0;
    end else begin
      state      <= state_next;
      i2c_exec   <= next_in_txn;
      busy       <= next_in_txn;
      temp_valid <= rd_ok;
      if ((state_next == ST_CFG_WAIT) && (state != ST_CFG_WAIT)) begin
        i2c_rd_wr_n  <= 1'b0;
        i2c_reg_addr <= CFG_REG;
      end else if ((state_next == ST_RD_WAIT) && (state != ST_RD_WAIT)) begin
        i2c_rd_wr_n  <= 1'b1;
        i2c_reg_addr <= TEMP_REG;
      end
      if ((state == ST_CFG_WAIT) && i2c_done) cfg_done <= 1'b1;
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

`ifdef TEMP_AVG_EN
  logic [7:0] hist [HIST_DEPTH];
  logic       primed;

  // hist[0] is the newest stored sample; the first good read fills every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed   <= 1'b0;
      temp_out <= 8'h00;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= 8'h00;
    end else if (rd_ok) begin
      primed <= 1'b1;
      if (!primed) begin
        temp_out <= i2c_r_data;
        for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= i2c_r_data;
      end else begin
        temp_out <= mean4(i2c_r_data, hist[0], hist[1], hist[2]);
        hist[0]  <= i2c_r_data;
        for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_out <= 8'h00;
    end else if (rd_ok) begin
      temp_out <= i2c_r_data;
    end
  end
`endif

endmodule
